// File: rtl/ci_status_poller.sv
// Custom-instruction initiator that periodically reads a responder's status counter and publishes it.
// Define CI_POLL_ALARM_EN to build the threshold comparator and sticky alarm; otherwise alarm is tied low.
module ci_status_poller #(
  parameter int unsigned TARGET_CI_ID = 42,
  parameter int unsigned POLL_PERIOD  = 1000,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned THRESHOLD    = 1
) (
  input  logic        systemClock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clearRequest,
  output logic        ciStart,
  output logic        ciCke,
  output logic [7:0]  ciN,
  output logic [31:0] ciValueA,
  output logic [31:0] ciValueB,
  input  logic [31:0] ciResult,
  input  logic        ciDone,
  output logic [31:0] lastValue,
  output logic        valueValid,
  output logic        alarm,
  output logic        timeoutError,
  output logic        busy
);

  localparam int unsigned   PW           = $clog2(POLL_PERIOD + 1);
  localparam int unsigned   TW           = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    CI_ID        = 8'(TARGET_CI_ID);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_WAIT_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic          clr_pend_q, clr_pend_d;
  logic          op_clear_q, op_clear_d;
  logic [31:0]   last_value_q, last_value_d;
  logic          valid_q, valid_d;
  logic          alarm_q, alarm_d;
  logic          timeout_err_q, timeout_err_d;

  logic in_txn;
  logic complete;
  logic timed_out;
  logic clear_wanted;
  logic hit_threshold;

  assign in_txn       = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
  assign complete     = in_txn && ciDone;
  assign timed_out    = (state_q == S_WAIT_DONE) && !ciDone && (timeout_cnt_q == TIMEOUT_LAST);
  assign clear_wanted = clr_pend_q || clearRequest;

`ifdef CI_POLL_ALARM_EN
  assign hit_threshold = (ciResult >= THRESHOLD);
`else
  logic unused_threshold;
  assign unused_threshold = ^THRESHOLD;
  assign hit_threshold    = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    clr_pend_d    = clr_pend_q || clearRequest;
    op_clear_d    = op_clear_q;
    last_value_d  = last_value_q;
    valid_d       = 1'b0;
    alarm_d       = alarm_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      S_IDLE: begin
        period_cnt_d = '0;
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) begin
          state_d      = S_IDLE;
          period_cnt_d = '0;
        end else if (clear_wanted || (period_cnt_q == PERIOD_LAST)) begin
          // The pending clear moves into the launched operation; later requests re-arm it.
          state_d       = S_ISSUE;
          period_cnt_d  = '0;
          timeout_cnt_d = '0;
          op_clear_d    = clear_wanted;
          clr_pend_d    = 1'b0;
        end else begin
          period_cnt_d = period_cnt_q + PW'(1);
        end
      end
      S_ISSUE: begin
        if (!ciDone) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!ciDone && (timeout_cnt_q != TIMEOUT_LAST)) timeout_cnt_d = timeout_cnt_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (complete || timed_out) begin
      state_d      = enable ? S_WAIT : S_IDLE;
      period_cnt_d = '0;
    end

    if (complete) begin
      valid_d = 1'b1;
      if (op_clear_q) begin
        last_value_d  = '0;
        alarm_d       = 1'b0;
        timeout_err_d = 1'b0;
      end else begin
        last_value_d = ciResult;
        if (hit_threshold) alarm_d = 1'b1;
      end
    end

    // A clear that timed out was never acknowledged, so keep it queued.
    if (timed_out) begin
      timeout_err_d = 1'b1;
      if (op_clear_q) clr_pend_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge systemClock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      period_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      clr_pend_q    <= 1'b0;
      op_clear_q    <= 1'b0;
      last_value_q  <= '0;
      valid_q       <= 1'b0;
      alarm_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      clr_pend_q    <= clr_pend_d;
      op_clear_q    <= op_clear_d;
      last_value_q  <= last_value_d;
      valid_q       <= valid_d;
      alarm_q       <= alarm_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Bus outputs are decoded from state so they vanish the instant reset asserts.
  assign busy         = in_txn;
  assign ciStart      = (state_q == S_ISSUE);
  assign ciCke        = in_txn;
  assign ciN          = in_txn ? CI_ID : 8'h00;
  assign ciValueA     = {31'b0, in_txn && op_clear_q};
  assign ciValueB     = '0;
  assign lastValue    = last_value_q;
  assign valueValid   = valid_q;
  assign alarm        = alarm_q;
  assign timeoutError = timeout_err_q;

endmodule

// File: tb/tb_ci_status_poller.sv
// Self-checking bench for ci_status_poller: a behavioural responder plus a scoreboard of expected
// published values, with directed scenarios for combinational/late/absent responders, clears and reset.
module tb_ci_status_poller;

  localparam int unsigned TARGET  = 42;
  localparam int unsigned PERIOD  = 10;
  localparam int unsigned TMO     = 8;
  localparam int unsigned THRESH  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_req = 1'b0;
  logic        ciStart, ciCke, ciDone;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB, ciResult, lastValue;
  logic        valueValid, alarm, timeoutError, busy;

  // Responder model: 0 = answers one cycle after start, 1 = answers in the start cycle, 2 = silent.
  int          mode = 0;
  logic [31:0] resp_val = '0;
  logic        resp_pend;

  int vectors = 0;
  int miscompares = 0;

  int   n_valid = 0;
  int   n_starts = 0;
  int   n_timeouts = 0;
  int   busy_len = 0;
  int   last_busy_len = 0;
  int   gap = 1000;
  logic model_pend = 1'b0;
  logic cur_op = 1'b0;
  logic done_seen = 1'b0;
  logic exp_alarm = 1'b0;
  logic exp_terr = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] sb_head;

  ci_status_poller #(
    .TARGET_CI_ID(TARGET),
    .POLL_PERIOD (PERIOD),
    .TIMEOUT     (TMO),
    .THRESHOLD   (THRESH)
  ) dut (
    .systemClock (clk),
    .reset       (rst_n),
    .enable      (enable),
    .clearRequest(clear_req),
    .ciStart     (ciStart),
    .ciCke       (ciCke),
    .ciN         (ciN),
    .ciValueA    (ciValueA),
    .ciValueB    (ciValueB),
    .ciResult    (ciResult),
    .ciDone      (ciDone),
    .lastValue   (lastValue),
    .valueValid  (valueValid),
    .alarm       (alarm),
    .timeoutError(timeoutError),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_pend <= 1'b0;
    else        resp_pend <= ciStart && (mode == 0);
  end

  assign ciDone   = rst_n && (((mode == 1) && ciStart) || resp_pend);
  assign ciResult = ciDone ? resp_val : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int count_of(input int sel);
    case (sel)
      0:       return n_valid;
      1:       return n_starts;
      default: return n_timeouts;
    endcase
  endfunction

  // Waits for a monitor event counter to reach target; an expired budget is a miscompare.
  task automatic wait_for(input string tag, input int sel, input int target);
    int k = 0;
    while (count_of(sel) < target && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (count_of(sel) < target) check(tag, count_of(sel), target);
  endtask

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_pend = 1'b0;
      cur_op     = 1'b0;
      done_seen  = 1'b0;
      exp_alarm  = 1'b0;
      exp_terr   = 1'b0;
      busy_len   = 0;
      gap        = 1000;
      sb.delete();
    end else begin
      if (ciStart) begin
        n_starts++;
        if (!model_pend) check("read_gap_ok", (gap >= PERIOD) ? 32'd1 : 32'd0, 32'd1);
        check("ci_n", ciN, TARGET);
        check("ci_value_a", ciValueA, {31'b0, model_pend});
        check("ci_value_b", ciValueB, 32'd0);
        check("ci_cke", ciCke, 1);
        cur_op     = model_pend;
        model_pend = 1'b0;
      end
      if (busy) begin
        busy_len++;
        gap = 0;
        if (ciDone) begin
          done_seen = 1'b1;
          if (cur_op) begin
            sb.push_back(32'd0);
            exp_alarm = 1'b0;
            exp_terr  = 1'b0;
          end else begin
            sb.push_back(resp_val);
`ifdef CI_POLL_ALARM_EN
            if (resp_val >= THRESH) exp_alarm = 1'b1;
`endif
          end
        end
      end else begin
        if (busy_len > 0) begin
          last_busy_len = busy_len;
          if (!done_seen) begin
            n_timeouts++;
            exp_terr = 1'b1;
            if (cur_op) model_pend = 1'b1;
          end
          check("idle_ci_cke", ciCke, 0);
          check("idle_ci_n", ciN, 0);
          check("idle_ci_value_a", ciValueA, 0);
          busy_len  = 0;
          done_seen = 1'b0;
        end
        gap++;
      end
      if (clear_req) model_pend = 1'b1;
      if (valueValid) begin
        n_valid++;
        if (sb.size() == 0) begin
          check("unexpected_valid", sb.size(), 1);
        end else begin
          sb_head = sb.pop_front();
          check("last_value", lastValue, sb_head);
          check("alarm", alarm, exp_alarm);
          check("timeout_error", timeoutError, exp_terr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    int s0, v0, t0;
    logic [31:0] vals [4];
    vals[0] = 32'h0000_0000;
    vals[1] = 32'h0000_0001;
    vals[2] = 32'hFFFF_FFFF;
    vals[3] = $urandom;

    // Reset state and a quiet bus while disabled.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ci_start", ciStart, 0);
    check("rst_ci_cke", ciCke, 0);
    check("rst_ci_n", ciN, 0);
    check("rst_ci_value_a", ciValueA, 0);
    check("rst_ci_value_b", ciValueB, 0);
    check("rst_last_value", lastValue, 0);
    check("rst_value_valid", valueValid, 0);
    check("rst_alarm", alarm, 0);
    check("rst_timeout_error", timeoutError, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    check("disabled_no_start", n_starts, 0);
    check("disabled_busy", busy, 0);

    // Combinational responder returning 0: no WAIT_DONE cycle, no alarm.
    #1 mode = 1; resp_val = 32'd0; enable = 1'b1;
    wait_for("wait_comb_valid", 0, 1);
    check("comb_busy_len", last_busy_len, 1);
    check("comb_last_value", lastValue, 0);
    check("comb_alarm", alarm, 0);

    // Responder answers one cycle after start with 3.
    #1 mode = 0; resp_val = 32'd3;
    wait_for("wait_read_valid", 0, 3);
    check("read_busy_len", last_busy_len, 2);
    check("read_last_value", lastValue, 3);

    // Silent responder: timeout after TMO cycles in WAIT_DONE, polling continues.
    #1 mode = 2;
    t0 = n_timeouts;
    wait_for("wait_timeout", 2, t0 + 1);
    check("timeout_busy_len", last_busy_len, TMO + 1);
    check("timeout_flag", timeoutError, 1);
    check("timeout_cke_low", ciCke, 0);
    s0 = n_starts;
    wait_for("wait_poll_after_timeout", 1, s0 + 1);
    wait_for("wait_second_timeout", 2, t0 + 2);

    // Clear from WAIT issues next cycle; a second clear during the reset operation is retained.
    #1 mode = 0; resp_val = 32'h55;
    v0 = n_valid;
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    @(negedge clk);
    check("clear_issue_next_cycle", ciStart, 1);
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    wait_for("wait_clear_valid", 0, v0 + 2);
    check("clear_last_value", lastValue, 0);
    check("clear_alarm", alarm, 0);
    check("clear_timeout_error", timeoutError, 0);

    // Boundary and random values, alternating late and combinational responders.
    for (int i = 0; i < 4; i++) begin
      #1 mode = i % 2; resp_val = vals[i];
      v0 = n_valid;
      wait_for("wait_table_valid", 0, v0 + 1);
    end

    // enable drops mid-transaction: the read completes, then polling stops.
    #1 mode = 0; resp_val = 32'd7;
    s0 = n_starts;
    v0 = n_valid;
    wait_for("wait_drop_start", 1, s0 + 1);
    #1 enable = 1'b0;
    wait_for("wait_drop_valid", 0, v0 + 1);
    check("drop_last_value", lastValue, 7);
    repeat (30) @(posedge clk);
    check("drop_no_more_polls", n_starts, s0 + 1);

    // Asynchronous reset in WAIT_DONE with a clear queued.
    #1 enable = 1'b1; mode = 2;
    s0 = n_starts;
    wait_for("wait_rst_start", 1, s0 + 1);
    #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_ci_cke", ciCke, 0);
    check("async_ci_start", ciStart, 0);
    check("async_busy", busy, 0);
    check("async_ci_n", ciN, 0);
    check("async_last_value", lastValue, 0);
    mode = 0; resp_val = 32'd9;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    v0 = n_valid;
    wait_for("wait_post_reset_valid", 0, v0 + 1);
    check("post_reset_last_value", lastValue, 9);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ci_status_poller.md
# ci_status_poller

Custom-instruction initiator that periodically reads a status counter exposed as a custom instruction, such as the bus error counter, and publishes the last value. It also raises an alarm on threshold and can clear the counter on request. It sits on the initiator side of the CI interface, in place of the CPU, so hardware can monitor counters without firmware polling.

## Interface
Parameters:
- TARGET_CI_ID, 42, ciN value of the polled responder (8 bit)
- POLL_PERIOD, 1000, cycles between the end of one transaction and the next read (≥2)
- TIMEOUT, 64, max cycles waiting for ciDone (≥1)
- THRESHOLD, 1, alarm when read value ≥ THRESHOLD

Ports:
- systemClock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  polling allowed while high
- clearRequest  in  1  one-cycle pulse; queue a reset operation (ciValueA=1)
- ciStart  out  1  CI start strobe
- ciCke  out  1  CI clock enable
- ciN  out  8  CI id
- ciValueA  out  32  operation: 0 = read, 1 = reset
- ciValueB  out  32  always 0
- ciResult  in  32  responder result, valid when ciDone=1
- ciDone  in  1  responder completion
- lastValue  out  32  last successfully read value
- valueValid  out  1  one-cycle pulse when lastValue updates
- alarm  out  1  sticky; lastValue ≥ THRESHOLD
- timeoutError  out  1  sticky; a transaction timed out
- busy  out  1  transaction in flight

## Operation
- Reset: all outputs 0, period counter 0, pending clear 0, state IDLE.
- States and transitions:
  - IDLE: go to WAIT when enable=1.
  - WAIT: count POLL_PERIOD cycles. When the count completes, go to ISSUE. If enable=0, go back to IDLE and zero the count.
  - ISSUE: one cycle. ciStart=1, ciCke=1, ciN=TARGET_CI_ID. ciValueA is 1 if a clear is pending, else 0. ciValueB=0. Go to WAIT_DONE.
  - WAIT_DONE: hold ciCke=1 and ciN/ciValueA. ciStart=0.
    - ciDone=1: latch the result, go to WAIT.
    - TIMEOUT cycles without ciDone: set timeoutError, go to WAIT.
- ciDone is also accepted in the ISSUE cycle (combinational responder). In that case the block skips WAIT_DONE and goes straight to WAIT.
- Outside ISSUE and WAIT_DONE, all ci* outputs are 0, so the block can share the bus.
- Read completion: lastValue←ciResult, valueValid pulses one cycle. alarm is set if ciResult ≥ THRESHOLD.
- Reset completion: lastValue←0, valueValid pulses, pending clear drops, alarm and timeoutError drop. The result value is ignored.
- clearRequest:
  - Latched into pending clear at any time.
  - The clear is issued at the next ISSUE, or immediately from WAIT (the period is skipped).
  - A clearRequest arriving during a reset operation in flight is retained.
- enable dropping mid-transaction: the transaction completes normally, then the block goes to IDLE.
- Asynchronous reset mid-transaction: all outputs go to 0 immediately and any pending clear is lost.
- Comparisons are unsigned, 32 bit. The period and timeout counters are wide enough for their parameter and saturate, never wrap.

## Timing
- Start-to-latch latency: ciDone in cycle k latches lastValue at edge k+1; valueValid is high in cycle k+1.
- ciStart is high for exactly one cycle per transaction and never high while busy from a prior transaction.
- busy is high from ISSUE through the cycle ciDone or timeout is sampled.
- Back-to-back reads are separated by ≥ POLL_PERIOD idle cycles.

## Configuration
- CI_POLL_ALARM_EN defined: threshold comparator and sticky alarm are present as described.
- CI_POLL_ALARM_EN undefined: no comparator, alarm tied to 0, THRESHOLD unused. All other behaviour is identical.

## Test plan
- Reset=0 then 1, enable=0 for 50 cycles -> all outputs 0, no ciStart.
- POLL_PERIOD=10, enable=1, responder returns 3 one cycle after start -> ciStart pulse every ≥10 cycles, ciN=42, ciValueA=0, lastValue=3, valueValid single pulse, alarm=1 (THRESHOLD=1).
- Responder asserts ciDone in the start cycle with result 0 -> lastValue=0, alarm stays 0, no WAIT_DONE cycle.
- Responder never answers, TIMEOUT=8 -> busy for 9 cycles, timeoutError=1, ci* return to 0, next poll still issued.
- clearRequest pulse during WAIT -> next cycle ciStart with ciValueA=1, ciValueB=0. On ciDone: lastValue=0, alarm=0, timeoutError=0.
- Reset asserted while in WAIT_DONE -> ciCke/ciStart/busy drop asynchronously. After release, polling restarts from IDLE with no pending clear.
